// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and lane helpers for the instruction/data memory arbiter.
// Pure declarations: no state, no latency.
package mem_arb_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        STORE,
        ERR_I,
        ERR_D
    } own_e;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    // Byte lane an access of this size starts on; reserved size 3 behaves as word.
    function automatic logic [1:0] lane_off(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return off;
            SZ_H:    return {off[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] be_for(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] base;
        case (size)
            SZ_B:    base = BE_B;
            SZ_H:    base = BE_H;
            default: base = BE_W;
        endcase
        return base << lane_off(size, off);
    endfunction

    function automatic logic [4:0] shift_amt(input logic [1:0] size, input logic [1:0] off);
        return {lane_off(size, off), 3'b000};
    endfunction

endpackage

// File: rtl/mem_arbiter_load_extract.sv
// Load lane select with sign/zero extension.
// Combinational, zero latency; no handshake.
module load_extract
    import mem_arb_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] result
);

    logic [31:0] shifted;

    always_comb begin
        shifted = word >> shift_amt(size, offset);
        case (size)
            SZ_B:    result = {{24{~uns & shifted[7]}}, shifted[7:0]};
            SZ_H:    result = {{16{~uns & shifted[15]}}, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one synchronous memory, data priority with fetch anti-starvation.
// Response 1 cycle after gnt; requesters stall by holding req until gnt, no response backpressure.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int             SW         = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0]  STREAK_MAX = SW'(MAX_D_STREAK);

    own_e          state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [1:0]    ld_size_q, ld_size_d;
    logic [1:0]    ld_off_q, ld_off_d;
    logic          ld_uns_q, ld_uns_d;
    logic          if_mis, d_mis;
    logic [31:0]   ld_data;

    always_comb begin
        if_mis = |if_addr[1:0];
        case (d_size)
            SZ_B:    d_mis = 1'b0;
            SZ_H:    d_mis = d_addr[0];
            default: d_mis = |d_addr[1:0];
        endcase
        // Data normally wins; a saturated streak hands one slot to a waiting fetch.
        if_gnt = if_req && (!d_req || streak_q == STREAK_MAX);
        d_gnt  = d_req && !if_gnt;
    end

    always_comb begin
        streak_d = streak_q;
        if (!if_req || if_gnt)
            streak_d = '0;
        else if (d_gnt && streak_q != STREAK_MAX)
            streak_d = streak_q + 1'b1;
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_wdata = 32'h0;
        mem_addr  = '0;
        if (if_gnt && !if_mis) begin
            mem_en   = 1'b1;
            mem_addr = {if_addr[ADDR_W-1:2], 2'b00};
        end else if (d_gnt && !d_mis) begin
            mem_en   = 1'b1;
            mem_addr = {d_addr[ADDR_W-1:2], 2'b00};
            if (d_we) begin
                mem_we    = 1'b1;
                mem_be    = be_for(d_size, d_addr[1:0]);
                mem_wdata = d_wdata << shift_amt(d_size, d_addr[1:0]);
            end
        end
    end

    always_comb begin
        state_d   = IDLE;
        ld_size_d = ld_size_q;
        ld_off_d  = ld_off_q;
        ld_uns_d  = ld_uns_q;
        if (if_gnt) begin
            state_d = if_mis ? ERR_I : FETCH;
        end else if (d_gnt) begin
            state_d   = d_mis ? ERR_D : (d_we ? STORE : LOAD);
            ld_size_d = d_size;
            ld_off_d  = d_addr[1:0];
            ld_uns_d  = d_unsigned;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            streak_q  <= '0;
            ld_size_q <= 2'b00;
            ld_off_q  <= 2'b00;
            ld_uns_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            streak_q  <= streak_d;
            ld_size_q <= ld_size_d;
            ld_off_q  <= ld_off_d;
            ld_uns_q  <= ld_uns_d;
        end
    end

    load_extract u_load_extract (
        .word   (mem_rdata),
        .offset (ld_off_q),
        .size   (ld_size_q),
        .uns    (ld_uns_q),
        .result (ld_data)
    );

    always_comb begin
        if_valid = 1'b0;
        if_rdata = 32'h0;
        if_err   = 1'b0;
        d_valid  = 1'b0;
        d_rdata  = 32'h0;
        d_err    = 1'b0;
        case (state_q)
            FETCH: begin
                if_valid = 1'b1;
                if_rdata = mem_rdata;
            end
            ERR_I: begin
                if_valid = 1'b1;
                if_err   = 1'b1;
            end
            LOAD: begin
                d_valid = 1'b1;
                d_rdata = ld_data;
            end
            STORE: d_valid = 1'b1;
            ERR_D: begin
                d_valid = 1'b1;
                d_err   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
